wb_stage: RTL

Write-back pipeline stage of the TinyMIPS core. It sits between the memory stage and the register file. It latches the memory-stage result, extracts and extends sub-word load data from the data RAM, and drives the register file write channel (`write_en` / `write_addr` / `write_data`). The register file forwards this channel to same-cycle readers, so these outputs are timing-critical and come straight from registered state plus a single extraction mux.

---
 rtl/wb_stage.sv | 87 ++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: TinyMIPS write-back stage; define WB_SUBWORD_LOAD_EN to enable LB/LBU/LH/LHU extraction
module wb_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_reg_write_en,
  input  logic [4:0]  mem_reg_write_addr,
  input  logic [31:0] mem_result,
  input  logic        mem_load_en,
  input  logic [2:0]  mem_load_type,
  input  logic [31:0] ram_read_data,
  output logic        write_en,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic [31:0] debug_pc,
  output logic [3:0]  debug_wen
);
  logic        r_valid, r_reg_write_en, r_load_en, r_fresh;
  logic [31:0] r_pc, r_result, r_load_hold;
  logic [4:0]  r_reg_addr;
  logic [2:0]  r_load_type;
  logic [31:0] w_raw, w_load;
  // WB register: reset and flush insert a bubble, stall holds and marks the RAM output stale
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_valid        <= 1'b0;
      r_pc           <= RESET_PC;
      r_reg_write_en <= 1'b0;
      r_reg_addr     <= '0;
      r_result       <= '0;
      r_load_en      <= 1'b0;
      r_load_type    <= '0;
      r_fresh        <= 1'b0;
    end else if (stall) begin
      r_fresh        <= 1'b0;
    end else begin
      r_valid        <= mem_valid;
      r_pc           <= mem_pc;
      r_reg_write_en <= mem_reg_write_en;
      r_reg_addr     <= mem_reg_write_addr;
      r_result       <= mem_result;
      r_load_en      <= mem_load_en;
      r_load_type    <= mem_load_type;
      r_fresh        <= 1'b1;
    end
  end
  // keep the first-cycle RAM word so a stalled load still sees its own data
  always_ff @(posedge clk) begin
    if (!rst) r_load_hold <= '0;
    else if (r_fresh) r_load_hold <= ram_read_data;
  end
  // RAM data is only valid in the first WB cycle; afterwards use the held copy
  always_comb w_raw = r_fresh ? ram_read_data : r_load_hold;
`ifdef WB_SUBWORD_LOAD_EN
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  // little-endian byte/halfword select with sign or zero extension
  always_comb begin
    w_byte = w_raw[{r_result[1:0], 3'b000} +: 8];
    w_half = r_result[1] ? w_raw[31:16] : w_raw[15:0];
    w_load = r_load_type == 3'd1 ? {{24{w_byte[7]}}, w_byte} :
             r_load_type == 3'd2 ? {24'd0, w_byte} :
             r_load_type == 3'd3 ? {{16{w_half[15]}}, w_half} :
             r_load_type == 3'd4 ? {16'd0, w_half} : w_raw;
  end
`else
  logic w_unused_load_type;
  // every load returns the full word; the load type is carried but ignored
  always_comb begin
    w_load = w_raw;
    w_unused_load_type = ^r_load_type;
  end
`endif
  // register file write channel and trace outputs straight from WB state
  always_comb begin
    write_en   = r_valid & r_reg_write_en & (r_reg_addr != 5'd0);
    write_addr = r_reg_addr;
    write_data = r_load_en ? w_load : r_result;
    debug_pc   = r_pc;
    debug_wen  = write_en ? 4'hf : 4'h0;
  end
endmodule
